// File: rtl/calc_pkg.sv
// Shared types and helpers for the calculator front end.
package calc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        PRESSED,
        RELEASE,
        REJECT
    } btn_state_e;

    // Width of a vector able to hold values 0..v-1, at least one bit.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/button_event_fifo.sv
// Small synchronous FIFO for button events.
// Read-pointer and write-pointer carry an extra wrap bit to tell full from empty.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module button_event_fifo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             full_o,
    input  logic             pop_i,
    output logic             empty_o,
    output logic [WIDTH-1:0] data_o
);

    localparam int unsigned PTR_W = (DEPTH <= 2) ? 1 : $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W:0]   wptr_q, wptr_d;
    logic [PTR_W:0]   rptr_q, rptr_d;
    logic             do_push;
    logic             do_pop;

    // Status flags, accepted push/pop and next pointer values.
    always_comb begin
        empty_o = (wptr_q == rptr_q);
        full_o  = (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]) && (wptr_q[PTR_W] != rptr_q[PTR_W]);
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
        wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = do_pop ? rptr_q + 1'b1 : rptr_q;
        data_o  = mem_q[rptr_q[PTR_W-1:0]];
    end

    // Pointer registers and storage array.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            if (do_push) begin
                mem_q[wptr_q[PTR_W-1:0]] <= data_i;
            end
        end
    end

endmodule

// File: rtl/button_event_encoder.sv
// Button front end: synchronise, debounce on a slow tick, accept only single presses,
// queue one index event per press for a valid/ready consumer.
// Optional feature macro: BUTTON_AUTO_REPEAT_EN (hold-to-repeat events while pressed).
module button_event_encoder
    import calc_pkg::*;
#(
    parameter int unsigned N_BUTTONS      = 16,
    parameter int unsigned DEBOUNCE_TICKS = 8,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned REPEAT_DELAY   = 500,
    parameter int unsigned REPEAT_PERIOD  = 100
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          tick_i,
    input  logic [N_BUTTONS-1:0]          buttons_i,
    output logic                          event_valid_o,
    input  logic                          event_ready_i,
    output logic [$clog2(N_BUTTONS)-1:0]  event_idx_o,
    output logic                          multi_press_o,
    output logic                          overflow_o
);

    localparam int unsigned IDX_W = clog2_min1(N_BUTTONS);
    localparam int unsigned CNT_W = clog2_min1(DEBOUNCE_TICKS + 1);
    localparam logic [CNT_W-1:0] DT_LAST = CNT_W'(DEBOUNCE_TICKS);

    // Parameter sanity, caught at elaboration.
    if (N_BUTTONS < 2) begin : g_bad_buttons
        $error("N_BUTTONS must be at least 2");
    end
    if (DEBOUNCE_TICKS < 1) begin : g_bad_debounce
        $error("DEBOUNCE_TICKS must be at least 1");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two, at least 2");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
    end

    logic [N_BUTTONS-1:0] sync1_q;
    logic [N_BUTTONS-1:0] sync2_q;

    logic                 sample_seen;
    logic                 sample_multi;
    logic                 sample_single;
    logic                 sample_none;
    logic [IDX_W-1:0]     sample_idx;

    btn_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     cnt_inc;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 push;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned HOLD_W   = clog2_min1(HOLD_MAX + 1);
    localparam logic [HOLD_W-1:0] HOLD_DELAY  = HOLD_W'(REPEAT_DELAY);
    localparam logic [HOLD_W-1:0] HOLD_PERIOD = HOLD_W'(REPEAT_PERIOD);

    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic [HOLD_W-1:0]    hold_inc;
    logic                 repeating_q, repeating_d;
`endif

    // Two-flop synchroniser for the raw asynchronous buttons.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= buttons_i;
            sync2_q <= sync1_q;
        end
    end

    // Classify the synchronised sample as none / single / multi; lowest set bit wins the index.
    always_comb begin
        sample_seen  = 1'b0;
        sample_multi = 1'b0;
        sample_idx   = '0;
        for (int i = 0; i < int'(N_BUTTONS); i++) begin
            if (sync2_q[i]) begin
                if (sample_seen) begin
                    sample_multi = 1'b1;
                end else begin
                    sample_idx = IDX_W'(i);
                end
                sample_seen = 1'b1;
            end
        end
        sample_none   = !sample_seen;
        sample_single = sample_seen && !sample_multi;
    end

    // Debounce FSM next state, counters and event push; only advances on tick cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        push    = 1'b0;
        cnt_inc = cnt_q + CNT_W'(1);
`ifdef BUTTON_AUTO_REPEAT_EN
        hold_d      = hold_q;
        repeating_d = repeating_q;
        hold_inc    = hold_q + HOLD_W'(1);
`endif
        if (tick_i) begin
            unique case (state_q)
                IDLE: begin
                    if (sample_multi) begin
                        state_d = REJECT;
                        cnt_d   = '0;
                    end else if (sample_single) begin
                        idx_d = sample_idx;
                        if (DEBOUNCE_TICKS == 1) begin
                            push    = 1'b1;
                            state_d = PRESSED;
                            cnt_d   = '0;
                        end else begin
                            state_d = DEBOUNCE;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                DEBOUNCE: begin
                    if (sample_multi) begin
                        state_d = REJECT;
                        cnt_d   = '0;
                    end else if (sample_none) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (sample_idx == idx_q) begin
                        if (cnt_inc == DT_LAST) begin
                            push    = 1'b1;
                            state_d = PRESSED;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        // A different single button restarts the debounce window.
                        idx_d = sample_idx;
                        cnt_d = CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (sample_multi) begin
                        state_d = REJECT;
                        cnt_d   = '0;
                    end else if (sample_none) begin
                        state_d = (DEBOUNCE_TICKS == 1) ? IDLE : RELEASE;
                        cnt_d   = (DEBOUNCE_TICKS == 1) ? '0 : CNT_W'(1);
                    end else begin
`ifdef BUTTON_AUTO_REPEAT_EN
                        // First repeat after the delay, then one every period.
                        if (hold_inc == (repeating_q ? HOLD_PERIOD : HOLD_DELAY)) begin
                            push        = 1'b1;
                            hold_d      = '0;
                            repeating_d = 1'b1;
                        end else begin
                            hold_d = hold_inc;
                        end
`endif
                    end
                end
                RELEASE: begin
                    if (sample_none) begin
                        if (cnt_inc == DT_LAST) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        // Release bounce: still the same press, no new event.
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end
                end
                REJECT: begin
                    if (sample_none) begin
                        if (cnt_inc == DT_LAST) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
`ifdef BUTTON_AUTO_REPEAT_EN
        if (state_d != PRESSED) begin
            hold_d      = '0;
            repeating_d = 1'b0;
        end
`endif
    end

    // FSM state, debounce counter and latched index.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

`ifdef BUTTON_AUTO_REPEAT_EN
    // Hold-time counter for auto-repeat; cleared whenever the FSM is not in PRESSED.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_q      <= '0;
            repeating_q <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            repeating_q <= repeating_d;
        end
    end
`endif

    button_event_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (idx_q),
        .full_o  (fifo_full),
        .pop_i   (pop),
        .empty_o (fifo_empty),
        .data_o  (event_idx_o)
    );

    // Handshake, status and drop indication.
    always_comb begin
        event_valid_o = !fifo_empty;
        pop           = event_valid_o && event_ready_i;
        overflow_o    = push && fifo_full && !pop;
        multi_press_o = (state_q == REJECT);
    end

endmodule

// File: tb/tb_button_event_encoder.sv
// Directed, table-driven bench for button_event_encoder (default parameters).
module tb_button_event_encoder;

    logic        clk;
    logic        rst_ni;
    logic        tick;
    logic [15:0] buttons;
    logic        ready;
    logic        valid;
    logic [3:0]  idx;
    logic        multi;
    logic        ovf;

    int checks = 0;
    int errors = 0;
    int ovf_cnt = 0;

    typedef struct {
        logic [15:0] btn;
        int          n;
        logic        v;
        logic [3:0]  idx;
        logic        m;
        int          ovf;
        logic        pop;
    } vec_t;

    vec_t tbl[$];

    button_event_encoder dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .tick_i        (tick),
        .buttons_i     (buttons),
        .event_valid_o (valid),
        .event_ready_i (ready),
        .event_idx_o   (idx),
        .multi_press_o (multi),
        .overflow_o    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count overflow pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_ni && ovf) ovf_cnt <= ovf_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic void add(input logic [15:0] b, input int n, input logic v,
                                input logic [3:0] i, input logic m, input int o,
                                input logic p);
        vec_t e;
        e.btn = b; e.n = n; e.v = v; e.idx = i; e.m = m; e.ovf = o; e.pop = p;
        tbl.push_back(e);
    endfunction

    // All tasks start and end one time unit after a rising edge.
    task automatic do_tick(input logic with_ready);
        tick  = 1'b1;
        ready = with_ready;
        @(posedge clk); #1;
        tick  = 1'b0;
        ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic run_ticks(input logic [15:0] b, input int n);
        buttons = b;
        repeat (3) @(posedge clk);
        #1;
        for (int t = 0; t < n; t++) do_tick(1'b0);
    endtask

    task automatic pop_one();
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
    endtask

    task automatic drain_expect(input string name, input int n, input logic [3:0] e0,
                                input logic [3:0] e1, input logic [3:0] e2,
                                input logic [3:0] e3);
        logic [3:0] exp_q [4];
        exp_q[0] = e0; exp_q[1] = e1; exp_q[2] = e2; exp_q[3] = e3;
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s valid%0d", name, k), int'(valid), 1);
            chk($sformatf("%s idx%0d", name, k), int'(idx), int'(exp_q[k]));
            pop_one();
        end
        chk($sformatf("%s empty", name), int'(valid), 0);
    endtask

    initial begin
        logic [15:0] fill [4];
        fill[0] = 16'h0002; fill[1] = 16'h0004; fill[2] = 16'h0008; fill[3] = 16'h0040;

        rst_ni = 1'b0; tick = 1'b0; ready = 1'b0; buttons = '0;
        repeat (3) @(posedge clk);
        #1 rst_ni = 1'b1;
        chk("reset valid", int'(valid), 0);
        chk("reset multi", int'(multi), 0);
        chk("reset ovf", int'(ovf), 0);
        chk("reset idx", int'(idx), 0);

        // Single press of idx 4, held past the debounce window.
        add(16'h0010, 7, 0, 0, 0, 0, 0);
        add(16'h0010, 1, 1, 4, 0, 0, 0);
        add(16'h0010, 2, 1, 4, 0, 0, 1);
        add(16'h0000, 8, 0, 0, 0, 0, 0);
        // Bounce, then stable press: exactly one event.
        for (int b = 0; b < 3; b++) begin
            add(16'h0010, 1, 0, 0, 0, 0, 0);
            add(16'h0000, 1, 0, 0, 0, 0, 0);
        end
        add(16'h0010, 7, 0, 0, 0, 0, 0);
        add(16'h0010, 1, 1, 4, 0, 0, 1);
        add(16'h0010, 3, 0, 0, 0, 0, 0);
        add(16'h0000, 8, 0, 0, 0, 0, 0);
        // Different single button restarts the count.
        add(16'h0004, 4, 0, 0, 0, 0, 0);
        add(16'h0008, 7, 0, 0, 0, 0, 0);
        add(16'h0008, 1, 1, 3, 0, 0, 1);
        add(16'h0000, 8, 0, 0, 0, 0, 0);
        // Two buttons: rejected, then recovery after 8 quiet ticks.
        add(16'h0011, 20, 0, 0, 1, 0, 0);
        add(16'h0000, 7, 0, 0, 1, 0, 0);
        add(16'h0000, 1, 0, 0, 0, 0, 0);
        add(16'h0020, 8, 1, 5, 0, 0, 1);
        add(16'h0000, 8, 0, 0, 0, 0, 0);
        // Five presses with consumer stalled: fifth is dropped.
        for (int p = 0; p < 4; p++) begin
            add(fill[p], 8, 1, 1, 0, 0, 0);
            add(16'h0000, 8, 1, 1, 0, 0, 0);
        end
        add(16'h0200, 8, 1, 1, 0, 1, 0);
        add(16'h0000, 8, 1, 1, 0, 1, 0);

        foreach (tbl[k]) begin
            run_ticks(tbl[k].btn, tbl[k].n);
            chk($sformatf("v%0d valid", k), int'(valid), int'(tbl[k].v));
            if (tbl[k].v) chk($sformatf("v%0d idx", k), int'(idx), int'(tbl[k].idx));
            chk($sformatf("v%0d multi", k), int'(multi), int'(tbl[k].m));
            chk($sformatf("v%0d ovf", k), ovf_cnt, tbl[k].ovf);
            if (tbl[k].pop) pop_one();
        end

        drain_expect("order", 4, 4'd1, 4'd2, 4'd3, 4'd6);

        // Full FIFO: push and pop in the same cycle, no overflow.
        for (int p = 0; p < 4; p++) begin
            run_ticks(fill[p], 8);
            run_ticks(16'h0000, 8);
        end
        run_ticks(16'h0200, 7);
        do_tick(1'b1);
        chk("pushpop ovf", ovf_cnt, 1);
        run_ticks(16'h0000, 8);
        drain_expect("pushpop", 4, 4'd2, 4'd3, 4'd6, 4'd9);

        // Hold-behaviour: auto-repeat cadence or exactly one event.
`ifdef BUTTON_AUTO_REPEAT_EN
        run_ticks(16'h0080, 8);
        chk("rep first", int'(valid), 1);
        chk("rep first idx", int'(idx), 7);
        pop_one();
        for (int r = 0; r < 3; r++) begin
            run_ticks(16'h0080, (r == 0) ? 499 : 99);
            chk($sformatf("rep gap%0d", r), int'(valid), 0);
            run_ticks(16'h0080, 1);
            chk($sformatf("rep ev%0d", r), int'(valid), 1);
            chk($sformatf("rep idx%0d", r), int'(idx), 7);
            pop_one();
        end
`else
        run_ticks(16'h0080, 8);
        chk("hold first", int'(valid), 1);
        chk("hold idx", int'(idx), 7);
        pop_one();
        run_ticks(16'h0080, 60);
        chk("hold no repeat", int'(valid), 0);
`endif
        run_ticks(16'h0000, 8);

        // Reset mid-press: must re-debounce from zero.
        run_ticks(16'h0100, 5);
        rst_ni = 1'b0;
        @(posedge clk); #1;
        rst_ni = 1'b1;
        chk("midrst valid", int'(valid), 0);
        chk("midrst multi", int'(multi), 0);
        run_ticks(16'h0100, 7);
        chk("midrst early", int'(valid), 0);
        run_ticks(16'h0100, 1);
        chk("midrst event", int'(valid), 1);
        chk("midrst idx", int'(idx), 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
